// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: R-type funct
// codes for the HI/LO instructions and small decode helpers.
package mdu_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    function automatic logic is_start_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // Every funct that touches HI/LO and therefore must wait for the unit.
    function automatic logic is_mdu_funct(input logic [5:0] f);
        return is_start_funct(f) ||
               (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 datapath: unsigned shift-add multiply or restoring shift-subtract
// divide on magnitudes, one step per cycle while step is high.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] result
);

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic              div_mode;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_part;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        div_part = acc[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, operand};
        acc_next = acc;
        if (div_mode) begin
            if (div_part >= {1'b0, operand}) begin
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{XLEN{1'b0}}, (is_div ? a : b)};
            operand  <= is_div ? b : a;
            div_mode <= is_div;
        end else if (step) begin
            acc      <= acc_next;
        end
    end

    assign result = acc;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: accepts MULT/MULTU/DIV/DIVU into private HI/LO,
// serves MTHI/MTLO/MFHI/MFLO, and stalls upstream while an operation runs.
module mdu
    import mdu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] rrs,
    input  logic [XLEN-1:0] rrt,
    input  logic            cancel,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rslt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo;
    logic              neg_q, neg_r, div_q, dz_q, done_q;

    logic              start_ok, op_signed, op_div, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] raw, prod;
    logic [XLEN-1:0]   quo, rem, fix_hi, fix_lo;

    // Handshake: an instruction is consumed on the edge where valid=1 and
    // stall=0; while stall=1 upstream holds funct/operands unchanged.
    assign busy      = (state != S_IDLE);
    assign stall     = valid && is_mdu_funct(funct) && busy;
    assign done      = done_q;
    assign rslt      = (funct == FUNCT_MFHI) ? hi : lo;
    assign dbg_state = state;

    assign start_ok  = (state == S_IDLE) && valid && !cancel && is_start_funct(funct);
    assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign op_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign sa        = op_signed && rrs[XLEN-1];
    assign sb        = op_signed && rrt[XLEN-1];
    assign mag_a     = sa ? -rrs : rrs;
    assign mag_b     = sb ? -rrt : rrt;

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (start_ok),
        .step   (state == S_RUN),
        .is_div (op_div),
        .a      (mag_a),
        .b      (mag_b),
        .result (raw)
    );

    // Sign correction; divide by zero keeps the all-ones quotient unsigned.
    always_comb begin
        prod   = neg_q ? -raw : raw;
        quo    = raw[XLEN-1:0];
        rem    = raw[2*XLEN-1:XLEN];
        fix_hi = prod[2*XLEN-1:XLEN];
        fix_lo = prod[XLEN-1:0];
        if (div_q) begin
            fix_lo = dz_q ? '1 : (neg_q ? -quo : quo);
            fix_hi = neg_r ? -rem : rem;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN: begin
                if (cancel)                          state_next = S_IDLE;
                else if (cnt == CNT_W'(XLEN - 1))    state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt   <= '0;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        div_q <= op_div;
                        dz_q  <= (rrt == '0);
                    end else if (valid && funct == FUNCT_MTHI) begin
                        hi <= rrs;
                    end else if (valid && funct == FUNCT_MTLO) begin
                        lo <= rrs;
                    end
                end
                S_RUN: cnt <= cnt + CNT_W'(1);
                S_FIX: begin
                    if (!cancel) begin
                        hi     <= fix_hi;
                        lo     <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: arithmetic reference model with per-cycle
// comparison, plus literal checks of the directed scenarios.
module tb_mdu;
    import mdu_pkg::*;

    localparam int X = 32;
    localparam int LAT = X + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [5:0]   funct = 6'h00;
    logic [X-1:0] rrs = '0;
    logic [X-1:0] rrt = '0;
    logic         cancel = 1'b0;
    logic         busy, stall, done;
    logic [X-1:0] rslt;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mdu #(.XLEN(X)) dut (
        .clk(clk), .rst(rst), .valid(valid), .funct(funct),
        .rrs(rrs), .rrt(rrt), .cancel(cancel),
        .busy(busy), .stall(stall), .done(done), .rslt(rslt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [X-1:0] act, input logic [X-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the architectural definition.
    function automatic void ref_op(input logic [5:0] f, input logic [X-1:0] a, input logic [X-1:0] b,
                                   output logic [X-1:0] h, output logic [X-1:0] l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        h = '0; l = '0;
        case (f)
            FUNCT_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                h = sp[63:32]; l = sp[31:0];
            end
            FUNCT_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                h = up[63:32]; l = up[31:0];
            end
            FUNCT_DIV: begin
                if (b == 0) begin l = '1; h = a; end
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin l = 32'h8000_0000; h = 0; end
                else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
            end
            FUNCT_DIVU: begin
                if (b == 0) begin l = '1; h = a; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Model state: architectural HI/LO, cycles left until writeback, done flag.
    logic [X-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;
    bit           m_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end
                end
            end else if (valid && !cancel && is_start_funct(funct)) begin
                ref_op(funct, rrs, rrt, p_hi, p_lo);
                m_left = LAT;
            end else if (valid && funct == FUNCT_MTHI) m_hi = rrs;
            else if (valid && funct == FUNCT_MTLO) m_lo = rrs;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            chk("busy",  {31'b0, busy},  {31'b0, m_left != 0});
            chk("done",  {31'b0, done},  {31'b0, m_done});
            chk("stall", {31'b0, stall}, {31'b0, valid && is_mdu_funct(funct) && (m_left != 0)});
            chk("rslt",  rslt, (funct == FUNCT_MFHI) ? m_hi : m_lo);
        end
    end

    task automatic op_lit(input logic [5:0] f, input logic [X-1:0] a, input logic [X-1:0] b,
                          input logic [X-1:0] eh, input logic [X-1:0] el);
        int  n = 0;
        int  dn = 0;
        bit  fin = 1'b0;
        @(posedge clk); #1 valid = 1'b1; funct = f; rrs = a; rrt = b;
        @(posedge clk); #1 valid = 1'b0; funct = 6'h00;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (done) dn++;
            if (!busy && n > 0) fin = 1'b1;
        end
        if (!fin) chk("op_timeout", 32'd0, 32'd1);
        chk("busy_cycles", n, LAT);
        chk("done_pulses", dn, 1);
        @(posedge clk); #1 valid = 1'b1; funct = FUNCT_MFHI;
        @(negedge clk); chk("lit_hi", rslt, eh);
        @(posedge clk); #1 funct = FUNCT_MFLO;
        @(negedge clk); chk("lit_lo", rslt, el);
        @(posedge clk); #1 valid = 1'b0; funct = 6'h00;
    endtask

    logic [5:0]   fl [8] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                             FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO};
    logic [X-1:0] sv [6] = '{32'h0, 32'hffff_ffff, 32'h8000_0000, 32'h1, 32'h7fff_ffff, 32'h2};

    function automatic logic [X-1:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return sv[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; funct = FUNCT_MFHI;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_rslt", rslt, 32'h0);

        op_lit(FUNCT_MULT,  32'hffff_fffd, 32'h7,         32'hffff_ffff, 32'hffff_ffeb);
        op_lit(FUNCT_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001);
        op_lit(FUNCT_DIV,   32'hffff_fff9, 32'h2,         32'hffff_ffff, 32'hffff_fffd);
        op_lit(FUNCT_DIVU,  32'h7,         32'h0,         32'h0000_0007, 32'hffff_ffff);
        op_lit(FUNCT_DIV,   32'h8000_0000, 32'hffff_ffff, 32'h0,         32'h8000_0000);

        // MTHI, DIV, stalled MFHI, then cancel mid-run.
        @(posedge clk); #1 valid = 1'b1; funct = FUNCT_MTHI; rrs = 32'h1234_5678;
        @(posedge clk); #1 funct = FUNCT_DIV; rrs = 32'd100; rrt = 32'd3;
        @(posedge clk); #1 valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 valid = 1'b1; funct = FUNCT_MFHI;
        @(negedge clk); chk("mfhi_stall", {31'b0, stall}, 32'd1);
        repeat (5) @(posedge clk);
        #1 valid = 1'b0; cancel = 1'b1;
        @(posedge clk); #1 cancel = 1'b0;
        @(negedge clk); chk("cancel_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1 valid = 1'b1; funct = FUNCT_MFHI;
        @(negedge clk); chk("cancel_hi", rslt, 32'h1234_5678);
        @(posedge clk); #1 valid = 1'b0;

        // Asynchronous reset in the middle of a MULT.
        @(posedge clk); #1 valid = 1'b1; funct = FUNCT_MULT; rrs = 32'd5; rrt = 32'd6;
        @(posedge clk); #1 valid = 1'b0; funct = FUNCT_MFHI;
        repeat (19) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", rslt, 32'h0);
        funct = FUNCT_MFLO;
        #1 chk("rst_lo", rslt, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            valid  = ($urandom_range(0, 3) != 0);
            funct  = ($urandom_range(0, 9) < 8) ? fl[$urandom_range(0, 7)] : 6'($urandom_range(32, 63));
            rrs    = pick_operand();
            rrt    = pick_operand();
            cancel = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #1 valid = 1'b0; cancel = 1'b0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
